// File: rtl/tagger_tab_commit.sv
// Double-buffered tagger partition table.
// Shadow writes are copied to the active bank after a quiescent drain.
module tagger_tab_commit #(
  parameter int unsigned NUM_PART      = 4,
  parameter int unsigned PATID_LEN     = 8,
  parameter int unsigned ADDR_W        = 48,
  parameter int unsigned GRAN_LOG2     = 2,
  parameter int unsigned MAX_OUTST     = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                cfg_we_i,
  input  logic [$clog2(NUM_PART)-1:0]         cfg_idx_i,
  input  logic [ADDR_W-GRAN_LOG2-1:0]         cfg_addr_i,
  input  logic [PATID_LEN-1:0]                cfg_patid_i,
  input  logic [1:0]                          cfg_conf_i,
  input  logic                                cfg_valid_i,
  output logic                                cfg_err_o,
  input  logic                                commit_req_i,
  output logic                                commit_busy_o,
  output logic                                commit_done_o,
  output logic                                commit_timeout_o,
  input  logic                                txn_start_i,
  input  logic                                txn_end_i,
  output logic                                stall_o,
  output logic [$clog2(MAX_OUTST+1)-1:0]      outstanding_o,
  output logic [NUM_PART*ADDR_W-1:0]          tab_addr_o,
  output logic [NUM_PART*PATID_LEN-1:0]       tab_patid_o,
  output logic [NUM_PART*2-1:0]               tab_conf_o,
  output logic [NUM_PART-1:0]                 tab_valid_o
);

  localparam int unsigned IDX_W = $clog2(NUM_PART);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST+1);
  localparam int unsigned GA_W  = ADDR_W - GRAN_LOG2;
  localparam int unsigned TO_W  =
    (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [IDX_W:0]   NP_V  = (IDX_W+1)'(NUM_PART);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_OUTST);
  localparam logic [TO_W-1:0]  TO_LAST =
    TO_W'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWAP
  } state_e;

  state_e           state_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             to_flag_q;
  logic [CNT_W-1:0] cnt_q;
  logic             idx_ok;
  logic             wr_ok;
  logic             to_hit;

  logic [GA_W-1:0]      sh_addr  [NUM_PART];
  logic [PATID_LEN-1:0] sh_patid [NUM_PART];
  logic [1:0]           sh_conf  [NUM_PART];
  logic                 sh_valid [NUM_PART];

  logic [GA_W-1:0]      ac_addr  [NUM_PART];
  logic [PATID_LEN-1:0] ac_patid [NUM_PART];
  logic [1:0]           ac_conf  [NUM_PART];
  logic                 ac_valid [NUM_PART];

  assign idx_ok = ({1'b0, cfg_idx_i} < NP_V);
  assign wr_ok  = cfg_we_i && idx_ok && (state_q == IDLE);
  assign to_hit = (DRAIN_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  assign stall_o       = (state_q != IDLE);
  assign commit_busy_o = (state_q != IDLE);
  assign outstanding_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      unique case (1'b1)
        txn_start_i && !txn_end_i: begin
          if (cnt_q != MAX_V) cnt_q <= cnt_q + 1'b1;
        end
        txn_end_i && !txn_start_i: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      to_cnt_q         <= '0;
      to_flag_q        <= 1'b0;
      commit_done_o    <= 1'b0;
      commit_timeout_o <= 1'b0;
    end else begin
      commit_done_o    <= 1'b0;
      commit_timeout_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (commit_req_i) begin
            state_q  <= DRAIN;
            to_cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= SWAP;
          end else if (to_hit) begin
            state_q   <= SWAP;
            to_flag_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        SWAP: begin
          commit_done_o    <= 1'b1;
          commit_timeout_o <= to_flag_q;
          to_flag_q        <= 1'b0;
          state_q          <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= cfg_we_i && !wr_ok;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_PART; i++) begin
        sh_addr[i]  <= '0;
        sh_patid[i] <= '0;
        sh_conf[i]  <= '0;
        sh_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_PART; i++) begin
        if (wr_ok && (cfg_idx_i == IDX_W'(i))) begin
          sh_addr[i]  <= cfg_addr_i;
          sh_patid[i] <= cfg_patid_i;
          sh_conf[i]  <= cfg_conf_i;
          sh_valid[i] <= cfg_valid_i;
        end
      end
    end
  end

  // Whole-bank copy on the SWAP exit edge keeps the tag-match view atomic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_PART; i++) begin
        ac_addr[i]  <= '0;
        ac_patid[i] <= '0;
        ac_conf[i]  <= '0;
        ac_valid[i] <= 1'b0;
      end
    end else if (state_q == SWAP) begin
      for (int i = 0; i < NUM_PART; i++) begin
        ac_addr[i]  <= sh_addr[i];
        ac_patid[i] <= sh_patid[i];
        ac_conf[i]  <= sh_conf[i];
        ac_valid[i] <= sh_valid[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PART; g++) begin : g_out
    assign tab_addr_o[g*ADDR_W +: ADDR_W] =
      ADDR_W'(ac_addr[g]) << GRAN_LOG2;
    assign tab_patid_o[g*PATID_LEN +: PATID_LEN] = ac_patid[g];
    assign tab_conf_o[g*2 +: 2] = ac_conf[g];
    assign tab_valid_o[g] = ac_valid[g];
  end

endmodule

// File: tb/tb_tagger_tab_commit.sv
// Bench for tagger_tab_commit: directed commit scenarios, then random
// traffic, all compared each cycle against a behavioural model.
module tb_tagger_tab_commit;

  localparam int NP = 3;
  localparam int PL = 8;
  localparam int AW = 48;
  localparam int GL = 2;
  localparam int MO = 16;
  localparam int TO = 8;
  localparam int IW = $clog2(NP);
  localparam int CW = $clog2(MO+1);
  localparam int GW = AW - GL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [GW-1:0] cfg_addr = '0;
  logic [PL-1:0] cfg_patid = '0;
  logic [1:0] cfg_conf = '0;
  logic cfg_valid = 1'b0;
  logic commit_req = 1'b0;
  logic txn_start = 1'b0;
  logic txn_end = 1'b0;

  logic cfg_err_o, commit_busy_o, commit_done_o, commit_timeout_o;
  logic stall_o;
  logic [CW-1:0] outstanding_o;
  logic [NP*AW-1:0] tab_addr_o;
  logic [NP*PL-1:0] tab_patid_o;
  logic [NP*2-1:0] tab_conf_o;
  logic [NP-1:0] tab_valid_o;

  int n_chk = 0;
  int n_fail = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  tagger_tab_commit #(
    .NUM_PART(NP), .PATID_LEN(PL), .ADDR_W(AW), .GRAN_LOG2(GL),
    .MAX_OUTST(MO), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_addr_i(cfg_addr),
    .cfg_patid_i(cfg_patid), .cfg_conf_i(cfg_conf),
    .cfg_valid_i(cfg_valid), .cfg_err_o(cfg_err_o),
    .commit_req_i(commit_req), .commit_busy_o(commit_busy_o),
    .commit_done_o(commit_done_o),
    .commit_timeout_o(commit_timeout_o),
    .txn_start_i(txn_start), .txn_end_i(txn_end),
    .stall_o(stall_o), .outstanding_o(outstanding_o),
    .tab_addr_o(tab_addr_o), .tab_patid_o(tab_patid_o),
    .tab_conf_o(tab_conf_o), .tab_valid_o(tab_valid_o)
  );

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 draining, 2 swapping.
  int m_cnt, m_phase, m_wait;
  bit m_flag, m_done, m_to, m_err;
  logic [GW-1:0] sh_a [NP];
  logic [PL-1:0] sh_p [NP];
  logic [1:0] sh_c [NP];
  bit sh_v [NP];
  logic [GW-1:0] ac_a [NP];
  logic [PL-1:0] ac_p [NP];
  logic [1:0] ac_c [NP];
  bit ac_v [NP];

  always @(posedge clk or negedge rst_n) begin : model
    int ph;
    if (!rst_n) begin
      m_cnt = 0; m_phase = 0; m_wait = 0;
      m_flag = 0; m_done = 0; m_to = 0; m_err = 0;
      for (int i = 0; i < NP; i++) begin
        sh_a[i] = '0; sh_p[i] = '0; sh_c[i] = '0; sh_v[i] = 0;
        ac_a[i] = '0; ac_p[i] = '0; ac_c[i] = '0; ac_v[i] = 0;
      end
    end else begin
      ph = m_phase;
      m_err = cfg_we && (ph != 0 || int'(cfg_idx) >= NP);
      if (ph == 0 && cfg_we && int'(cfg_idx) < NP) begin
        sh_a[cfg_idx] = cfg_addr;
        sh_p[cfg_idx] = cfg_patid;
        sh_c[cfg_idx] = cfg_conf;
        sh_v[cfg_idx] = cfg_valid;
      end
      m_done = 0;
      m_to = 0;
      if (ph == 0) begin
        if (commit_req) begin
          m_phase = 1;
          m_wait = 0;
        end
      end else if (ph == 1) begin
        if (m_cnt == 0) m_phase = 2;
        else if (TO != 0 && m_wait == TO - 1) begin
          m_phase = 2;
          m_flag = 1;
        end else m_wait++;
      end else begin
        for (int i = 0; i < NP; i++) begin
          ac_a[i] = sh_a[i]; ac_p[i] = sh_p[i];
          ac_c[i] = sh_c[i]; ac_v[i] = sh_v[i];
        end
        m_done = 1;
        m_to = m_flag;
        m_flag = 0;
        m_phase = 0;
      end
      if (txn_start && !txn_end && m_cnt < MO) m_cnt++;
      else if (txn_end && !txn_start && m_cnt > 0) m_cnt--;
    end
  end

  always @(negedge clk) begin : compare
    logic [NP*AW-1:0] e_a;
    logic [NP*PL-1:0] e_p;
    logic [NP*2-1:0] e_c;
    logic [NP-1:0] e_v;
    if (run) begin
      for (int i = 0; i < NP; i++) begin
        e_a[i*AW +: AW] = AW'(ac_a[i]) * (2 ** GL);
        e_p[i*PL +: PL] = ac_p[i];
        e_c[i*2 +: 2] = ac_c[i];
        e_v[i] = ac_v[i];
      end
      chk("m_stall", stall_o, m_phase != 0);
      chk("m_busy", commit_busy_o, m_phase != 0);
      chk("m_done", commit_done_o, m_done);
      chk("m_timeout", commit_timeout_o, m_to);
      chk("m_err", cfg_err_o, m_err);
      chk("m_outst", outstanding_o, m_cnt);
      chk("m_addr", tab_addr_o, e_a);
      chk("m_patid", tab_patid_o, e_p);
      chk("m_conf", tab_conf_o, e_c);
      chk("m_valid", tab_valid_o, e_v);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cfg_we = 0; commit_req = 0; txn_start = 0; txn_end = 0;
  endtask

  task automatic wr(input int idx, input logic [GW-1:0] a,
                    input logic [PL-1:0] p, input logic [1:0] c,
                    input bit v);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_addr = a;
    cfg_patid = p; cfg_conf = c; cfg_valid = v;
  endtask

  int nd;

  initial begin
    step(); step();
    rst_n = 1;
    run = 1;
    chk("rst_valid", tab_valid_o, 0);
    chk("rst_outst", outstanding_o, 0);
    chk("rst_busy", commit_busy_o, 0);
    chk("rst_stall", stall_o, 0);

    // Basic commit
    wr(1, 46'h1000, 8'h5A, 2'd2, 1);
    step(); clr();
    commit_req = 1;
    step(); clr();
    chk("t1_valid_t1", tab_valid_o, 0);
    chk("t1_stall_t1", stall_o, 1);
    step();
    chk("t1_done_t2", commit_done_o, 0);
    step();
    chk("t1_addr", tab_addr_o[AW +: AW], 48'h4000);
    chk("t1_patid", tab_patid_o[PL +: PL], 8'h5A);
    chk("t1_conf", tab_conf_o[2 +: 2], 2'd2);
    chk("t1_valid", tab_valid_o, 3'b010);
    chk("t1_done", commit_done_o, 1);
    chk("t1_stall_t3", stall_o, 0);
    step();
    chk("t1_done_once", commit_done_o, 0);

    // Drain
    txn_start = 1;
    repeat (3) step();
    clr();
    commit_req = 1;
    step(); clr();
    for (int k = 1; k <= 9; k++) begin
      chk("t2_stall", stall_o, 1);
      if (k == 8) chk("t2_cnt0", outstanding_o, 0);
      txn_end = (k >= 5 && k <= 7);
      step();
    end
    clr();
    chk("t2_done", commit_done_o, 1);
    chk("t2_no_to", commit_timeout_o, 0);
    chk("t2_stall_off", stall_o, 0);

    // Timeout
    txn_start = 1;
    step(); clr();
    commit_req = 1;
    step(); clr();
    for (int k = 1; k <= 9; k++) begin
      chk("t3_no_done", commit_done_o, 0);
      step();
    end
    chk("t3_done", commit_done_o, 1);
    chk("t3_to", commit_timeout_o, 1);
    txn_end = 1;
    step(); clr();

    // Dropped writes and ignored second commit
    commit_req = 1;
    step(); clr();
    wr(0, 46'h777, 8'h11, 2'd1, 1);
    commit_req = 1;
    step(); clr();
    chk("t4_err_drain", cfg_err_o, 1);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      nd += int'(commit_done_o);
    end
    chk("t4_one_done", nd, 1);
    wr(3, 46'h999, 8'h22, 2'd3, 1);
    step(); clr();
    chk("t4_err_idx", cfg_err_o, 1);
    step();
    chk("t4_err_clear", cfg_err_o, 0);
    commit_req = 1;
    step(); clr();
    step(); step();
    chk("t4_valid", tab_valid_o, 3'b010);
    chk("t4_addr0", tab_addr_o[0 +: AW], 0);

    // Counter corners
    txn_start = 1; txn_end = 1;
    step(); clr();
    chk("t5_hold", outstanding_o, 0);
    txn_end = 1;
    step(); clr();
    chk("t5_underflow", outstanding_o, 0);
    txn_start = 1;
    repeat (MO + 3) step();
    clr();
    chk("t5_sat", outstanding_o, 16);

    // Reset mid-commit
    commit_req = 1;
    step(); clr();
    step();
    chk("t6_in_drain", stall_o, 1);
    rst_n = 0;
    #1;
    chk("t6_valid", tab_valid_o, 0);
    chk("t6_busy", commit_busy_o, 0);
    chk("t6_outst", outstanding_o, 0);
    step(); step();
    rst_n = 1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      nd += int'(commit_done_o);
    end
    chk("t6_no_done", nd, 0);
    chk("t6_valid_after", tab_valid_o, 0);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_idx = IW'($urandom_range(0, 3));
      cfg_addr = GW'({$urandom, $urandom});
      cfg_patid = PL'($urandom);
      cfg_conf = 2'($urandom);
      cfg_valid = 1'($urandom);
      commit_req = ($urandom_range(0, 15) == 0);
      txn_start = ($urandom_range(0, 2) == 0);
      txn_end = ($urandom_range(0, 2) == 0);
      step();
    end
    clr();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tagger_tab_commit.md
# tagger_tab_commit

Double-buffered partition table for the transaction tagger, with a quiescent commit protocol. Software writes partition entries into a shadow bank at any time outside a commit. A commit request first stalls new transactions and drains the in-flight ones, or times out. It then copies the shadow bank atomically into the active bank, which drives the address-match/tagging logic. This block sits between the tagger register file and the tag-match datapath, and replaces the free-running commit path.

## Interface

**Parameters**

- `NUM_PART`, default 4: number of partition entries (≥2).
- `PATID_LEN`, default 8: partition ID width.
- `ADDR_W`, default 48: full address width of a table entry.
- `GRAN_LOG2`, default 2: log2 of the address granule. The low `GRAN_LOG2` bits of every entry address are zero.
- `MAX_OUTST`, default 16: saturation value of the outstanding-transaction counter.
- `DRAIN_TIMEOUT`, default 1024: drain cycles before a forced swap. A value of 0 disables the timeout.

**Ports** (reset `rst_ni`, asynchronous, active-low; clock `clk_i`)

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `cfg_we_i` in 1: shadow write strobe.
- `cfg_idx_i` in `$clog2(NUM_PART)`: entry index. Indices ≥ `NUM_PART` are dropped.
- `cfg_addr_i` in `ADDR_W-GRAN_LOG2`: entry address, in granule units.
- `cfg_patid_i` in `PATID_LEN`: entry partition ID.
- `cfg_conf_i` in 2: entry mode/config bits.
- `cfg_valid_i` in 1: entry enable.
- `cfg_err_o` out 1: one-cycle pulse when a write is dropped.
- `commit_req_i` in 1: commit request, single-cycle pulse.
- `commit_busy_o` out 1: high while FSM ≠ IDLE.
- `commit_done_o` out 1: one-cycle pulse, coincident with the new active table.
- `commit_timeout_o` out 1: one-cycle pulse, coincident with `commit_done_o` when the drain timed out.
- `txn_start_i` in 1: a transaction was accepted downstream.
- `txn_end_i` in 1: a transaction completed.
- `stall_o` out 1: upstream must not start transactions.
- `outstanding_o` out `$clog2(MAX_OUTST+1)`: current outstanding count.
- `tab_addr_o` out `NUM_PART × ADDR_W`: active entry addresses.
- `tab_patid_o` out `NUM_PART × PATID_LEN`: active partition IDs.
- `tab_conf_o` out `NUM_PART × 2`: active config bits.
- `tab_valid_o` out `NUM_PART`: active enables.

## Operation

**Shadow bank**
- In IDLE, a write with `cfg_we_i` and a legal index updates shadow[idx] on the clock edge: address, patid, conf and valid.
- Writes in DRAIN or SWAP, or with an illegal index, are dropped. `cfg_err_o` is high the following cycle.

**Entry address**
- The active address is `{addr_granule, GRAN_LOG2'b0}`. Stored width is `ADDR_W-GRAN_LOG2`.

**Outstanding counter**
- Increment on `txn_start_i`; decrement on `txn_end_i`; hold when both are asserted.
- Saturates at `MAX_OUTST`.
- `txn_end_i` at 0 is ignored (no underflow).
- `txn_start_i` while `stall_o` is high is a protocol violation. It is still counted.

**Commit FSM**
- IDLE: `commit_req_i` moves to DRAIN and clears the timeout counter.
- DRAIN:
  - `stall_o` = 1.
  - If the registered count is 0, go to SWAP.
  - Otherwise, if `DRAIN_TIMEOUT` ≠ 0 and the timeout counter equals `DRAIN_TIMEOUT-1`, go to SWAP and set the timeout flag.
  - Otherwise increment the timeout counter.
- SWAP:
  - `stall_o` = 1.
  - On the exit edge: active ← shadow for all entries; `commit_done_o` is registered high; `commit_timeout_o` is registered with the flag; the flag is cleared; go to IDLE.
- `commit_req_i` outside IDLE is ignored. No queueing.

**Reset values**
- Shadow and active banks: all zero (`tab_valid_o` = 0).
- FSM: IDLE.
- Counters: 0.
- All pulse outputs: 0.
- `stall_o` = 0, `commit_busy_o` = 0.
- Reset mid-DRAIN or mid-SWAP aborts the commit. The active bank stays zero.

## Timing

- `commit_req_i` in cycle t with count 0 and no traffic:
  - DRAIN at t+1, SWAP at t+2.
  - New table and `commit_done_o` at t+3.
  - `stall_o` and `commit_busy_o` high in t+1..t+2, low at t+3.
- Minimum commit latency is 3 cycles. Drain adds 1 cycle per cycle the count is nonzero in DRAIN.
- A `cfg_we_i` write in the same cycle t as `commit_req_i` lands in shadow and is included in the commit.
- A timed-out commit with a constant nonzero count swaps at cycle t+1+`DRAIN_TIMEOUT`. Done and timeout pulse one cycle later.
- All outputs are registered except `commit_busy_o` and `stall_o`, which are decoded from the state register.

## Test plan

1. **Basic commit.** After reset, write idx 1: granule addr 0x1000, patid 0x5A, conf 2, valid 1. Pulse commit at t with no traffic.
   -> Nothing changes before t+3. At t+3: `tab_addr_o[1]` = 0x4000, patid 0x5A, conf 2, `tab_valid_o` = 4'b0010, `commit_done_o` for exactly 1 cycle.
2. **Drain.** Start 3 transactions, commit at t, end one transaction per cycle from t+5.
   -> `stall_o` high t+1..t+9. Count reaches 0 at t+8. Done at t+10, no timeout pulse.
3. **Timeout.** With `DRAIN_TIMEOUT`=8, start 1 transaction and never end it; commit at t.
   -> Swap with `commit_done_o` and `commit_timeout_o` both at t+10.
4. **Dropped writes.** Write in DRAIN, write with idx = `NUM_PART` in IDLE, second commit pulse in DRAIN.
   -> `cfg_err_o` pulses for both writes. Shadow is unchanged. Only one done pulse.
5. **Counter corners.** Simultaneous start+end holds the count. End at 0 leaves it 0. `MAX_OUTST`+3 starts saturate at 16.
6. **Reset mid-commit.** Assert `rst_ni` low during DRAIN.
   -> FSM returns to IDLE, all table outputs are 0, no done pulse after release.
